// File: rtl/pkt_arb_pkg.sv
// Shared types and stats register map for the packet merge arbiter.
package pkt_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        WAIT = 2'd1,
        PKT  = 2'd2
    } arb_state_t;

    // Counter addresses as seen through stats_packer_avlstrm
    localparam logic [7:0] REG_ARB_PKT0 = 8'h00;
    localparam logic [7:0] REG_ARB_PKT1 = 8'h01;
    localparam logic [7:0] REG_ARB_PKT2 = 8'h02;
    localparam logic [7:0] REG_ARB_PKT3 = 8'h03;
    localparam logic [7:0] REG_ARB_PKT4 = 8'h04;
    localparam logic [7:0] REG_ARB_PKT5 = 8'h05;
    localparam logic [7:0] REG_ARB_PKT6 = 8'h06;
    localparam logic [7:0] REG_ARB_PKT7 = 8'h07;
    localparam logic [7:0] REG_ARB_ERR  = 8'h08;

endpackage

// File: rtl/pkt_merge_arb_avlstrm_rr_pick.sv
// Rotating-start priority encoder: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pkt_merge_arb_avlstrm.sv
// Packet-atomic weighted round-robin merge of N_IN Avalon-ST streams.
module pkt_merge_arb_avlstrm
    import pkt_arb_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int WIDTH    = 512,
    parameter int EMPTY_W  = 6,
    parameter int WEIGHT_W = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [N_IN*WIDTH-1:0]    in_data,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0]          in_sop,
    input  logic [N_IN-1:0]          in_eop,
    input  logic [N_IN*EMPTY_W-1:0]  in_empty,
    output logic [N_IN-1:0]          in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [EMPTY_W-1:0]       out_empty,
    input  logic                     out_ready,
    input  logic [N_IN*WEIGHT_W-1:0] cfg_weight,
    output logic [N_IN*32-1:0]       stats_pkt,
    output logic [31:0]              stats_err
);

    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = $clog2(N_IN + 1);

    arb_state_t state;
    logic [PTR_W-1:0] ptr, sel, grant_idx, cur, ptr_nxt;
    logic [WEIGHT_W-1:0] used, used_nxt, w_eff;
    logic [WEIGHT_W:0] new_used;
    logic grant_vld, hs, start_hs, eop_hs;
    logic [N_IN-1:0] orphan;
    logic [CNT_W-1:0] n_orph;
    logic [32:0] err_sum;

    logic [N_IN-1:0][WIDTH-1:0]    data_arr;
    logic [N_IN-1:0][EMPTY_W-1:0]  empty_arr;
    logic [N_IN-1:0][WEIGHT_W-1:0] w_arr;
    logic [N_IN-1:0][31:0]         pkt_cnt;

    assign data_arr  = in_data;
    assign empty_arr = in_empty;
    assign w_arr     = cfg_weight;
    assign stats_pkt = pkt_cnt;

    rr_pick #(.N(N_IN), .PTR_W(PTR_W)) u_pick (
        .req       (in_valid & in_sop),
        .ptr       (ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // In ARB the candidate is shown immediately; afterwards sel is frozen
    always_comb begin
        cur       = (state == ARB) ? grant_idx : sel;
        out_valid = (state == ARB) ? grant_vld : in_valid[cur];
        out_data  = data_arr[cur];
        out_sop   = in_sop[cur];
        out_eop   = in_eop[cur];
        out_empty = empty_arr[cur];
        orphan    = (state == ARB) ? (in_valid & ~in_sop) : '0;
        in_ready  = orphan;
        if (out_valid) in_ready[cur] = out_ready;
    end

    assign hs       = out_valid & out_ready;
    assign start_hs = hs & (state != PKT);
    assign eop_hs   = hs & out_eop;

    // Weighted pointer update applied on each packet-start handshake
    always_comb begin
        w_eff    = (w_arr[cur] == '0) ? WEIGHT_W'(1) : w_arr[cur];
        new_used = (cur == ptr) ? ({1'b0, used} + 1'b1) : (WEIGHT_W + 1)'(1);
        if (new_used >= {1'b0, w_eff}) begin
            ptr_nxt  = (cur == PTR_W'(N_IN - 1)) ? '0 : cur + 1'b1;
            used_nxt = '0;
        end else begin
            ptr_nxt  = cur;
            used_nxt = new_used[WEIGHT_W-1:0];
        end
    end

    always_comb begin
        n_orph = '0;
        for (int i = 0; i < N_IN; i++) n_orph = n_orph + CNT_W'(orphan[i]);
        err_sum = {1'b0, stats_err} + 33'(n_orph);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ARB;
            sel   <= '0;
            ptr   <= '0;
            used  <= '0;
        end else begin
            if (start_hs) begin
                ptr  <= ptr_nxt;
                used <= used_nxt;
            end
            case (state)
                ARB: if (grant_vld) begin
                    sel <= grant_idx;
                    if (!out_ready)   state <= WAIT;
                    else if (!out_eop) state <= PKT;
                end
                WAIT: if (hs) state <= out_eop ? ARB : PKT;
                PKT:  if (eop_hs) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) stats_err <= '0;
        else     stats_err <= err_sum[32] ? '1 : err_sum[31:0];
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_cnt
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst)                                  pkt_cnt[i] <= '0;
            else if (eop_hs && cur == PTR_W'(i))      pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_merge_arb_avlstrm.sv
// Directed scoreboard bench for pkt_merge_arb_avlstrm with two small inputs.
module tb_pkt_merge_arb_avlstrm;

    localparam int N = 2, W = 32, EW = 2, WW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [N*EW-1:0] in_empty;
    logic [W-1:0]    out_data;
    logic            out_valid, out_sop, out_eop, out_ready;
    logic [EW-1:0]   out_empty;
    logic [N*WW-1:0] cfg_weight;
    logic [N*32-1:0] stats_pkt;
    logic [31:0]     stats_err;

    pkt_merge_arb_avlstrm #(.N_IN(N), .WIDTH(W), .EMPTY_W(EW), .WEIGHT_W(WW)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_ready(out_ready),
        .cfg_weight(cfg_weight), .stats_pkt(stats_pkt), .stats_err(stats_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       q0[$], q1[$];
    logic [33:0] exp_q[$];
    int          tests = 0, fails = 0;
    logic [1:0]  en;
    logic        toggle, stall_prev;
    logic [31:0] stall_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int id, input int nb, input int nexp);
        for (int b = 0; b < nb; b++) begin
            beat_t x;
            x.d   = {8'(src), 8'(id), 8'(b), 8'hA5};
            x.sop = (b == 0);
            x.eop = (b == nb - 1);
            if (src == 0) q0.push_back(x); else q1.push_back(x);
            if (b < nexp) exp_q.push_back({x.sop, x.eop, x.d});
        end
    endtask

    task automatic add_orph(input int src, input int n);
        for (int b = 0; b < n; b++) begin
            beat_t x;
            x.d   = {8'(src), 8'hEE, 8'(b), 8'hA5};
            x.sop = 1'b0;
            x.eop = (b == n - 1);
            if (src == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic drive();
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
        if (en[0] && q0.size() != 0) begin
            in_valid[0] = 1'b1; in_sop[0] = q0[0].sop; in_eop[0] = q0[0].eop;
            in_data[31:0] = q0[0].d;
        end
        if (en[1] && q1.size() != 0) begin
            in_valid[1] = 1'b1; in_sop[1] = q1[0].sop; in_eop[1] = q1[0].eop;
            in_data[63:32] = q1[0].d;
        end
    endtask

    // One cycle: check output on the falling edge, retire accepted source beats after the rise
    task automatic tick();
        logic [1:0] hs;
        @(negedge Clk);
        if (stall_prev && out_valid) chk("stall_hold", 64'(out_data), 64'(stall_data));
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (out_valid && out_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_extra observed=%0h expected=none", out_data);
            end
            if (exp_q.size() != 0)
                chk("sb_beat", 64'({out_sop, out_eop, out_data}), 64'(exp_q.pop_front()));
        end
        hs = in_valid & in_ready;
        @(posedge Clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (toggle) out_ready = ~out_ready;
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int  n = 0;
        logic done;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        done = (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0);
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin
        Rst = 1'b1; out_ready = 1'b1; en = 2'b11; toggle = 1'b0; stall_prev = 1'b0;
        stall_data = '0; cfg_weight = {4'd1, 4'd1};
        drive();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_stats_pkt", 64'(stats_pkt), 64'(0));
        chk("rst_stats_err", 64'(stats_err), 64'(0));
        @(posedge Clk); #1;
        Rst = 1'b0;

        // weights 1/1, single-beat packets: strict alternation
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, k, 1, 1);
            add_pkt(1, k, 1, 1);
        end
        drive();
        run("t1_done", 50);
        chk("t1_pkt0", 64'(stats_pkt[31:0]), 64'(4));
        chk("t1_pkt1", 64'(stats_pkt[63:32]), 64'(4));

        // weights 3/1, two-beat packets: 0,0,0,1,0,0,0,1
        cfg_weight = {4'd1, 4'd3};
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) add_pkt(0, 10 + r * 3 + k, 2, 2);
            add_pkt(1, 10 + r, 2, 2);
        end
        drive();
        run("t2_done", 100);
        chk("t2_pkt0", 64'(stats_pkt[31:0]), 64'(10));
        chk("t2_pkt1", 64'(stats_pkt[63:32]), 64'(6));

        // 4-beat packet under toggling ready, competing sop arrives mid-packet
        cfg_weight = {4'd1, 4'd1};
        add_pkt(0, 20, 4, 4);
        drive();
        toggle = 1'b1;
        tick();
        add_pkt(1, 20, 1, 1);
        drive();
        run("t3_done", 100);
        toggle = 1'b0; out_ready = 1'b1;
        chk("t3_pkt0", 64'(stats_pkt[31:0]), 64'(11));
        chk("t3_pkt1", 64'(stats_pkt[63:32]), 64'(7));

        // stalled sop on input 1 keeps its slot over the higher-priority input 0
        out_ready = 1'b0; en = 2'b10;
        add_pkt(1, 30, 2, 2);
        add_pkt(0, 30, 1, 1);
        drive();
        repeat (5) tick();
        #1;
        chk("t4_wait_valid", 64'(out_valid), 64'(1));
        chk("t4_wait_data", 64'(out_data), 64'({8'd1, 8'd30, 8'd0, 8'hA5}));
        en = 2'b11;
        drive();
        repeat (2) tick();
        #1;
        chk("t4_hold_data", 64'(out_data), 64'({8'd1, 8'd30, 8'd0, 8'hA5}));
        out_ready = 1'b1;
        run("t4_done", 50);
        chk("t4_pkt0", 64'(stats_pkt[31:0]), 64'(12));
        chk("t4_pkt1", 64'(stats_pkt[63:32]), 64'(8));

        // orphan beats while idle are drained and counted, never forwarded
        add_orph(1, 3);
        drive();
        run("t5_done", 20);
        chk("t5_err", 64'(stats_err), 64'(3));
        chk("t5_pkt1", 64'(stats_pkt[63:32]), 64'(8));

        // reset in the middle of a packet; the tail becomes orphans
        add_pkt(0, 40, 4, 2);
        drive();
        tick();
        tick();
        Rst = 1'b1; en = 2'b00;
        drive();
        #1;
        chk("t6_rst_pkt", 64'(stats_pkt), 64'(0));
        chk("t6_rst_err", 64'(stats_err), 64'(0));
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        @(posedge Clk); #1;
        Rst = 1'b0; en = 2'b11;
        drive();
        run("t6_drain", 20);
        chk("t6_err", 64'(stats_err), 64'(2));
        chk("t6_pkt", 64'(stats_pkt), 64'(0));
        // pointer back at input 0 after reset
        add_pkt(0, 50, 1, 1);
        add_pkt(1, 50, 1, 1);
        drive();
        run("t6_ptr", 20);
        chk("t6_pkt_after", 64'(stats_pkt), {32'd1, 32'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_merge_arb_avlstrm.md
# pkt_merge_arb_avlstrm

Packet-atomic weighted round-robin arbiter merging `N_IN` Avalon-ST packet streams onto one output stream. It recombines the fast-path bypass (`fp_nocheck`) and checked-packet (`out_pkt`) streams of the string-matcher stage before the next stage. It also serves any other point where several packet streams share one downstream consumer. Each packet passes intact, never interleaved, with per-input packet counts and a protocol-error count exported for the stats packer.

## Interface
- `N_IN`, 2, number of input streams (2..8)
- `WIDTH`, 512, data beat width in bits
- `EMPTY_W`, 6, empty field width
- `WEIGHT_W`, 4, per-input weight width

- `Clk`  in  1  single clock for the whole block
- `Rst`  in  1  reset, asynchronous, active-high
- `in_data`  in  N_IN*WIDTH  input beats, input i at [i*WIDTH +: WIDTH]
- `in_valid` / `in_sop` / `in_eop`  in  N_IN each  per-input Avalon-ST qualifiers
- `in_empty`  in  N_IN*EMPTY_W  per-input empty
- `in_ready`  out  N_IN  per-input ready
- `out_data`  out  WIDTH  merged output beat
- `out_valid` / `out_sop` / `out_eop`  out  1 each  output qualifiers
- `out_empty`  out  EMPTY_W  output empty
- `out_ready`  in  1  downstream ready
- `cfg_weight`  in  N_IN*WEIGHT_W  maximum consecutive packets per input; 0 is treated as 1
- `stats_pkt`  out  N_IN*32  per-input count of forwarded packets (eop handshakes)
- `stats_err`  out  32  count of dropped orphan beats

## Operation
- FSM states:
  - ARB: select an input.
  - WAIT: selection latched, sop beat stalled.
  - PKT: mid-packet.
- ARB selection:
  - Candidate = first input with `in_valid & in_sop`, scanning from `ptr` upward with wrap.
  - The candidate is presented on the output in the same cycle.
  - Candidate handshake (`out_ready`) with eop: stay in ARB. Without eop: go to PKT with `sel` latched.
  - Candidate valid but `!out_ready`: latch `sel` and go to WAIT. The selection must not change while `out_valid` is high.
- WAIT: present the `sel` input. On handshake, go to ARB if eop, else to PKT.
- PKT: present the `sel` input. A handshake carrying eop returns to ARB. Other inputs have `in_ready=0`.
- Commit happens on the sop handshake of input g:
  - If g==ptr: `used++`. When `used+1 >= max(weight[g],1)`, set ptr=g+1 mod N_IN and used=0.
  - If g!=ptr: set ptr=g and used=1, then apply the same advance check.
- Orphan beats: in ARB, any input presenting `in_valid & !in_sop` gets `in_ready=1` and its beat is dropped. `stats_err` increments by the number of such inputs in that cycle, saturating at 2^32-1.
- A sop arriving while in PKT on the `sel` input is forwarded unchanged. No error is flagged because the block does not check framing mid-packet.
- `stats_pkt[i]` increments on each eop handshake from input i and wraps modulo 2^32.
- `cfg_weight` is sampled at each commit. Changes take effect at the next sop handshake.

## Timing
- Zero-cycle datapath: `out_*` are combinational muxes of the inputs selected by FSM/`sel`. `in_ready[sel] = out_ready`.
- No bubble between packets: an eop handshake in PKT followed by a waiting sop on another input is forwarded on the next cycle.
- Reset values:
  - state=ARB, ptr=0, used=0, sel=0
  - stats=0
  - `out_valid=0` while no input is valid
  - all `in_ready=0` except orphan drains
- Reset asserted mid-packet: the FSM returns to ARB immediately. The rest of that packet is then treated as orphan beats, which are dropped and counted.
- Simultaneous eop handshake and new orphan beat on another input: the orphan is not drained until the FSM is in ARB.

## Structure
- Shared package `pkt_arb_pkg`:
  - FSM state enum `arb_state_t` {ARB, WAIT, PKT}
  - stats register address constants `REG_ARB_PKT0..7` and `REG_ARB_ERR`, for wrapping the counters with `stats_packer_avlstrm`
- Sub-module `rr_pick`: rotating-start priority encoder. Inputs are an `N_IN` request vector and `ptr`. Outputs are `grant_idx` and `grant_vld`. It is purely combinational and reusable.

## Test plan
- N_IN=2, weights 1/1, both inputs stream 1-beat packets, `out_ready=1` -> output alternates 0,1,0,1; `stats_pkt`={n,n}.
- Weights 3/1, both saturated with 2-beat packets -> grant order 0,0,0,1,0,0,0,1; beats never interleaved.
- Input 0 starts a 4-beat packet, `out_ready` toggles 1010, input 1 sop arrives mid-packet -> all 4 input-0 beats precede input 1; output data is stable while stalled.
- Sop presented with `out_ready=0` for 5 cycles, then a higher-priority input becomes valid -> the original selection is held (WAIT), then forwarded.
- Input 1 presents 3 beats without sop while idle -> all 3 dropped, `stats_err`=3, no output beats.
- Assert `Rst` for 1 cycle mid-packet -> state=ARB, counters=0; trailing beats are counted as orphans.
